// File: rtl/jtag_readback_tx_if.sv
// Push-side handshake bundle for the JTAG readback transmitter.
// A fabric producer (master) offers in_data with in_valid. The
// transmitter (slave) takes the word on any CLK edge where both
// in_valid and in_ready are high.
//   in_data  : word to queue for readback
//   in_valid : in_data is valid
//   in_ready : transmitter FIFO has room
interface jtag_readback_tx_if #(
    parameter int WORD_W = 48
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/jtag_readback_tx.sv
// Return-path transmitter for the virtual-JTAG link.
// Fabric words are queued in a small FIFO. Each capture-DR (cdr && sel)
// presents the head word as a WORD_W+1 bit frame: a flag bit first, then
// the payload LSB first. The frame goes out on tdo, one bit per qualified
// shift strobe. The word is popped only once the host has shifted the
// whole frame, so a host that re-captures mid-frame sees the same word again.
// Ports:
//   CLK, reset   : system clock, synchronous active-high reset
//   in_if        : push handshake (in_data / in_valid / in_ready)
//   sel          : readback instruction selected (level)
//   cdr          : capture-DR pulse
//   sdr          : shift-DR level
//   shift_stb    : one pulse per synchronised tck rising edge
//   tdo          : registered serial data out
//   fifo_count   : words queued, 0..DEPTH
//   frames_sent  : completed non-empty frames, wraps at 16 bits
module jtag_readback_tx #(
    parameter int WORD_W = 48,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                CLK,
    input  logic                reset,
    jtag_readback_tx_if.slave   in_if,
    input  logic                sel,
    input  logic                cdr,
    input  logic                sdr,
    input  logic                shift_stb,
    output logic                tdo,
    output logic [ADDR_W:0]     fifo_count,
    output logic [15:0]         frames_sent
);
    localparam int FRAME_W = WORD_W + 1;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]  BIT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [15:0]       FRAME_ONE = 16'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [FRAME_W-1:0]  sreg;
    logic [CNT_W-1:0]    bit_cnt;
    logic                hit;

    logic capture;
    logic do_shift;
    logic last_shift;
    logic push;
    logic pop;
    logic not_empty;

    assign in_if.in_ready = (fifo_count != CNT_FULL);
    assign not_empty      = (fifo_count != '0);
    assign push           = in_if.in_valid && in_if.in_ready;

    // Capture has priority over a shift strobe in the same cycle.
    assign capture    = cdr && sel;
    assign do_shift   = shift_stb && sdr && sel && (state == SHIFT) && !capture;
    assign last_shift = do_shift && (bit_cnt == LAST_IDX);
    // Empty frames never pop; only a fully shifted real word leaves the FIFO.
    assign pop        = last_shift && hit;

    // FIFO storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= in_if.in_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            sreg        <= '0;
            bit_cnt     <= '0;
            hit         <= 1'b0;
            tdo         <= 1'b0;
            frames_sent <= '0;
            state       <= IDLE;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase

            if (capture) begin
                // Peek at the head using the pre-edge FIFO contents.
                sreg    <= not_empty ? {mem[rd_ptr], 1'b1} : '0;
                hit     <= not_empty;
                bit_cnt <= '0;
                tdo     <= not_empty;
                state   <= SHIFT;
            end else begin
                if (do_shift) begin
                    sreg    <= {1'b0, sreg[FRAME_W-1:1]};
                    bit_cnt <= bit_cnt + BIT_ONE;
                    if (last_shift) begin
                        state <= DONE;
                        if (hit) begin
                            frames_sent <= frames_sent + FRAME_ONE;
                        end
                    end
                end
                // Deselect blanks tdo without disturbing the frame; on
                // reselect the current bit reappears.
                if (!sel) begin
                    tdo <= 1'b0;
                end else if (do_shift) begin
                    tdo <= sreg[1];
                end else if (state == SHIFT) begin
                    tdo <= sreg[0];
                end else begin
                    tdo <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_jtag_readback_tx.sv
module tb_jtag_readback_tx;
    localparam int WORD_W  = 48;
    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 3;
    localparam int FRAME_W = WORD_W + 1;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic              reset = 1'b0;
    logic              sel = 1'b0;
    logic              cdr = 1'b0;
    logic              sdr = 1'b0;
    logic              shift_stb = 1'b0;
    logic              tdo;
    logic [ADDR_W:0]   fifo_count;
    logic [15:0]       frames_sent;

    jtag_readback_tx_if #(.WORD_W(WORD_W)) in_if ();

    jtag_readback_tx #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .in_if       (in_if),
        .sel         (sel),
        .cdr         (cdr),
        .sdr         (sdr),
        .shift_stb   (shift_stb),
        .tdo         (tdo),
        .fifo_count  (fifo_count),
        .frames_sent (frames_sent)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WORD_W-1:0]  mq [$];
    logic [FRAME_W-1:0] mframe = '0;
    int                 mcnt = 0;
    bit                 mhit = 1'b0;
    int                 mstate = 0;   // 0 idle, 1 shift, 2 done
    int unsigned        mframes = 0;
    bit                 exp_q [$];
    logic [FRAME_W-1:0] hist = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One CLK cycle of stimulus; model predicts, scoreboard compares after the edge.
    task automatic cycle(input bit r, input bit c, input bit s, input bit d,
                         input bit st, input bit pv, input logic [WORD_W-1:0] pw);
        bit cap, sh, ok, e;
        reset = r; cdr = c; sel = s; sdr = d; shift_stb = st;
        in_if.in_valid = pv; in_if.in_data = pw;
        cap = c && s;
        sh  = st && d && s && (mstate == 1) && !cap;
        ok  = pv && (mq.size() < DEPTH);
        if (r)               e = 1'b0;
        else if (cap)        e = (mq.size() != 0);
        else if (!s)         e = 1'b0;
        else if (sh)         e = mframe[1];
        else if (mstate == 1) e = mframe[0];
        else                 e = 1'b0;
        exp_q.push_back(e);
        if (r) begin
            mq.delete(); mframe = '0; mcnt = 0; mhit = 1'b0; mstate = 0; mframes = 0;
        end else begin
            if (cap) begin
                mhit   = (mq.size() != 0);
                mframe = mhit ? {mq[0], 1'b1} : '0;
                mcnt   = 0;
                mstate = 1;
            end else if (sh) begin
                mframe = mframe >> 1;
                mcnt++;
                if (mcnt == FRAME_W) begin
                    mstate = 2;
                    if (mhit) begin
                        void'(mq.pop_front());
                        mframes = (mframes + 1) & 32'hFFFF;
                    end
                end
            end
            if (ok) mq.push_back(pw);
        end
        @(posedge CLK);
        #1;
        reset = 1'b0; cdr = 1'b0; shift_stb = 1'b0; in_if.in_valid = 1'b0;
        hist = {tdo, hist[FRAME_W-1:1]};
        chk("tdo", tdo, exp_q.pop_front());
        chk("fifo_count", fifo_count, mq.size());
        chk("frames_sent", frames_sent, mframes);
        chk("in_ready", in_if.in_ready, mq.size() != DEPTH);
    endtask

    task automatic shifts(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 1, 1, 1, 0, '0);
    endtask

    task automatic capture();
        cycle(0, 1, 1, 1, 0, 0, '0);
    endtask

    task automatic push(input logic [WORD_W-1:0] w);
        cycle(0, 0, 1, 1, 0, 1, w);
    endtask

    initial begin
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;

        // Reset state
        cycle(1, 0, 0, 0, 0, 0, '0);
        cycle(1, 0, 0, 0, 0, 0, '0);
        chk("rst_tdo", tdo, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_frames", frames_sent, 0);

        // Empty FIFO frame
        capture();
        shifts(48);
        chk("empty_frame", hist, 0);
        shifts(1);
        chk("empty_frames_sent", frames_sent, 0);
        chk("empty_count", fifo_count, 0);

        // Single word 0xA5
        push(48'h0000_0000_00A5);
        capture();
        shifts(48);
        chk("a5_frame", hist, 49'h14B);
        chk("a5_count_pre", fifo_count, 1);
        shifts(1);
        chk("a5_count_post", fifo_count, 0);
        chk("a5_frames", frames_sent, 1);

        // Fill to full, overflow attempt refused
        for (int i = 0; i < DEPTH; i++) push(48'h1000 + 48'(i));
        chk("full_ready", in_if.in_ready, 0);
        chk("full_count", fifo_count, 8);
        push(48'hDEAD);
        chk("overflow_count", fifo_count, 8);
        capture();
        shifts(48);
        chk("full_head_frame", hist, {48'h1000, 1'b1});
        cycle(0, 0, 1, 1, 1, 1, 48'hBEEF);   // push while full on the pop edge
        chk("full_pop_push", fifo_count, 7);
        capture();
        shifts(48);
        chk("second_head_frame", hist, {48'h1001, 1'b1});
        cycle(0, 0, 1, 1, 1, 1, 48'hCAFE);   // push and pop together
        chk("pop_push_count", fifo_count, 7);
        chk("pop_push_frames", frames_sent, 3);

        // Aborted frame re-presents the same word
        cycle(1, 0, 1, 1, 0, 0, '0);
        push(48'h123);
        capture();
        shifts(20);
        chk("abort_count", fifo_count, 1);
        capture();
        shifts(48);
        chk("retry_frame", hist, {48'h123, 1'b1});
        chk("retry_count_pre", fifo_count, 1);
        shifts(1);
        chk("retry_count_post", fifo_count, 0);
        chk("retry_frames", frames_sent, 1);

        // Shift strobes ignored with sdr=0 or sel=0
        push(48'h5A5A_0000_F00D);
        capture();
        shifts(10);
        cycle(0, 0, 1, 0, 1, 0, '0);
        cycle(0, 0, 1, 0, 1, 0, '0);
        cycle(0, 0, 0, 1, 1, 0, '0);
        chk("desel_tdo", tdo, 0);
        cycle(0, 0, 0, 1, 1, 0, '0);
        cycle(0, 0, 1, 1, 0, 0, '0);
        shifts(38);
        chk("pause_count_pre", fifo_count, 1);
        shifts(1);
        chk("pause_frames", frames_sent, 2);

        // Capture and push together: capture sees the empty FIFO
        cycle(0, 1, 1, 1, 0, 1, 48'h77);
        shifts(48);
        chk("cap_push_frame", hist, 0);
        shifts(1);
        chk("cap_push_count", fifo_count, 1);
        capture();
        shifts(49);
        chk("cap_push_drain", fifo_count, 0);

        // Reset mid-frame with words queued
        push(48'h1); push(48'h2); push(48'h3);
        capture();
        shifts(30);
        cycle(1, 0, 1, 1, 0, 0, '0);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_tdo", tdo, 0);
        capture();
        shifts(48);
        chk("midrst_empty_frame", hist, 0);
        shifts(1);
        chk("midrst_frames", frames_sent, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
